bf_addsub_0: RTL and testbench

Butterfly add/sub back-end paired with the shared K/D modular multiplier. When an operand pair is issued to the multiplier, this block captures the butterfly top operand `u`, delays it to meet the multiplier result `t`, and computes (u+t) mod q and (u−t) mod q. An optional final halving stage applies ×2⁻¹ mod q for INTT scaling. It supports Kyber (q=3329, two 12-bit lanes) and Dilithium (q=8380417, one 23-bit lane), counts butterflies per stage, and drives write-back to coefficient memory.

---
 rtl/bf_addsub_0_pkg.sv | 29 ++
 rtl/bf_addsub_0_lane.sv | 54 +++++
 rtl/bf_addsub_0.sv | 135 +++++++++++++
 tb/tb_bf_addsub_0.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/bf_addsub_0_pkg.sv
// Shared constants and types for the butterfly add/sub back-end.
// Moduli, mode encodings and the tag carried alongside each multiplier issue.
package bf_addsub_0_pkg;

  localparam int Q_K    = 3329;
  localparam int Q_D    = 8380417;
  localparam int K_W    = 12;
  localparam int D_W    = 23;
  localparam int DATA_W = 24;

  localparam logic MODE_K = 1'b0;
  localparam logic MODE_D = 1'b1;

  typedef struct packed {
    logic              valid;
    logic              mode;
    logic              half_en;
    logic [DATA_W-1:0] u;
  } tag_t;

  function automatic logic [DATA_W-1:0] pack_k(logic [K_W-1:0] hi, logic [K_W-1:0] lo);
    return {hi, lo};
  endfunction

  function automatic logic [DATA_W-1:0] pack_d(logic [D_W-1:0] v);
    return {1'b0, v};
  endfunction

endpackage

// File: rtl/bf_addsub_0_lane.sv
// One modular add/sub lane: registered (u+t) mod Q and (u-t) mod Q,
// followed by an optional combinational halving (x * 2^-1 mod Q) on the registered values.
module mod_addsub_lane
  import bf_addsub_0_pkg::*;
#(
  parameter int WIDTH = K_W,
  parameter int Q     = Q_K
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             half_en,
  input  logic [WIDTH-1:0] u,
  input  logic [WIDTH-1:0] t,
  output logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y
);

  localparam logic [WIDTH:0] QE = (WIDTH+1)'(Q);

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] sum_r;
  logic [WIDTH-1:0] dif_r;
  logic             half_r;

  always_comb begin
    sum = {1'b0, u} + {1'b0, t};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum_r  <= '0;
      dif_r  <= '0;
      half_r <= 1'b0;
    end else if (load) begin
      sum_r  <= WIDTH'((sum >= QE) ? (sum - QE) : sum);
      dif_r  <= (u >= t) ? (u - t) : WIDTH'({1'b0, u} + QE - {1'b0, t});
      half_r <= half_en;
    end
  end

  // Odd values get +Q first so the shift stays exact; the sum needs one extra bit.
  function automatic logic [WIDTH-1:0] halve(logic [WIDTH-1:0] v);
    logic [WIDTH:0] w;
    w = v[0] ? ({1'b0, v} + QE) : {1'b0, v};
    return WIDTH'(w >> 1);
  endfunction

  always_comb begin
    x = half_r ? halve(sum_r) : sum_r;
    y = half_r ? halve(dif_r) : dif_r;
  end

endmodule

// File: rtl/bf_addsub_0.sv
// Butterfly back-end: delays u to meet the multiplier result t, computes
// (u+t) mod q and (u-t) mod q with optional halving, and indexes outputs per stage.
module bf_addsub_0
  import bf_addsub_0_pkg::*;
#(
  parameter int MUL_LAT      = 4,
  parameter int BF_PER_STAGE = 128,
  parameter int CNT_W        = $clog2(BF_PER_STAGE)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] u,
  input  logic              mode,
  input  logic              half_en,
  input  logic [DATA_W-1:0] t,
  output logic              out_valid,
  output logic [DATA_W-1:0] x,
  output logic [DATA_W-1:0] y,
  output logic [CNT_W-1:0]  out_idx,
  output logic              stage_done
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(BF_PER_STAGE - 1);

  tag_t dly [MUL_LAT];
  tag_t tag_in;
  tag_t tag_out;

  logic s1_valid;
  logic s1_mode;

  logic [K_W-1:0] k_lo_x, k_lo_y, k_hi_x, k_hi_y;
  logic [D_W-1:0] d_x, d_y;

  logic [DATA_W-1:0] x_nxt, y_nxt;
  logic [CNT_W-1:0]  idx_inc, idx_nxt;

  always_comb begin
    tag_in         = '0;
    tag_in.valid   = in_valid;
    tag_in.mode    = mode;
    tag_in.half_en = half_en;
    tag_in.u       = u;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < MUL_LAT; i++) dly[i] <= '0;
    end else begin
      dly[0] <= tag_in;
      for (int i = 1; i < MUL_LAT; i++) dly[i] <= dly[i-1];
    end
  end

  assign tag_out = dly[MUL_LAT-1];

  // All three lanes load every butterfly; the registered mode picks the result.
  mod_addsub_lane #(.WIDTH(K_W), .Q(Q_K)) u_lane_k_lo (
    .clk     (clk),
    .rst     (rst),
    .load    (tag_out.valid),
    .half_en (tag_out.half_en),
    .u       (tag_out.u[K_W-1:0]),
    .t       (t[K_W-1:0]),
    .x       (k_lo_x),
    .y       (k_lo_y)
  );

  mod_addsub_lane #(.WIDTH(K_W), .Q(Q_K)) u_lane_k_hi (
    .clk     (clk),
    .rst     (rst),
    .load    (tag_out.valid),
    .half_en (tag_out.half_en),
    .u       (tag_out.u[DATA_W-1:K_W]),
    .t       (t[DATA_W-1:K_W]),
    .x       (k_hi_x),
    .y       (k_hi_y)
  );

  mod_addsub_lane #(.WIDTH(D_W), .Q(Q_D)) u_lane_d (
    .clk     (clk),
    .rst     (rst),
    .load    (tag_out.valid),
    .half_en (tag_out.half_en),
    .u       (tag_out.u[D_W-1:0]),
    .t       (t[D_W-1:0]),
    .x       (d_x),
    .y       (d_y)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_mode  <= MODE_K;
    end else begin
      s1_valid <= tag_out.valid;
      if (tag_out.valid) s1_mode <= tag_out.mode;
    end
  end

  always_comb begin
    x_nxt = pack_k(k_hi_x, k_lo_x);
    y_nxt = pack_k(k_hi_y, k_lo_y);
    if (s1_mode == MODE_D) begin
      x_nxt = pack_d(d_x);
      y_nxt = pack_d(d_y);
    end
  end

  // stage_done is registered, so it looks ahead at the index the output will carry.
  always_comb begin
    idx_inc = (out_idx == LAST) ? '0 : (out_idx + CNT_W'(1));
    idx_nxt = out_valid ? idx_inc : out_idx;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid  <= 1'b0;
      x          <= '0;
      y          <= '0;
      out_idx    <= '0;
      stage_done <= 1'b0;
    end else begin
      out_valid  <= s1_valid;
      stage_done <= s1_valid && (idx_nxt == LAST);
      out_idx    <= idx_nxt;
      if (s1_valid) begin
        x <= x_nxt;
        y <= y_nxt;
      end
    end
  end

endmodule

// File: tb/tb_bf_addsub_0.sv
// Bench for bf_addsub_0: fixed vectors, stage wrap, mid-flight reset and
// random sparse traffic against an integer modular-arithmetic model.
module tb_bf_addsub_0;

  localparam int MUL_LAT = 4;
  localparam int BF      = 128;
  localparam int CW      = 7;
  localparam longint QK  = 3329;
  localparam longint QD  = 8380417;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid = 1'b0;
  logic [23:0]   u = '0;
  logic          mode = 1'b0;
  logic          half_en = 1'b0;
  logic [23:0]   t = '0;
  logic          out_valid;
  logic [23:0]   x;
  logic [23:0]   y;
  logic [CW-1:0] out_idx;
  logic          stage_done;

  always #5 clk = ~clk;

  bf_addsub_0 #(.MUL_LAT(MUL_LAT), .BF_PER_STAGE(BF), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .u          (u),
    .mode       (mode),
    .half_en    (half_en),
    .t          (t),
    .out_valid  (out_valid),
    .x          (x),
    .y          (y),
    .out_idx    (out_idx),
    .stage_done (stage_done)
  );

  typedef struct { int due; logic [23:0] x; logic [23:0] y; } exp_t;
  typedef struct { int tcyc; logic [23:0] t; } tdrv_t;
  typedef struct { bit md; bit he; logic [23:0] u; logic [23:0] t; logic [23:0] ex; logic [23:0] ey; } vec_t;

  exp_t  exp_q[$];
  tdrv_t t_q[$];
  vec_t  vt[8];

  int cyc    = 0;
  int n_cmp  = 0;
  int n_fail = 0;
  int idx_m  = 0;
  int sd_cnt = 0;

  task automatic cmp(string name, logic [31:0] act, logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0d, expected %0d", name, cyc, act, req);
    end
  endtask

  function automatic longint lane_op(longint a, longint b, longint q, bit he, bit sub);
    longint r;
    r = sub ? (a - b + q) % q : (a + b) % q;
    if (he) r = (r * ((q + 1) / 2)) % q;
    return r;
  endfunction

  function automatic logic [23:0] ref_bf(bit md, bit he, logic [23:0] a, logic [23:0] b, bit sub);
    logic [23:0] res;
    if (md) begin
      res = {1'b0, 23'(lane_op(longint'(a[22:0]), longint'(b[22:0]), QD, he, sub))};
    end else begin
      res = {12'(lane_op(longint'(a[23:12]), longint'(b[23:12]), QK, he, sub)),
             12'(lane_op(longint'(a[11:0]), longint'(b[11:0]), QK, he, sub))};
    end
    return res;
  endfunction

  function automatic logic [23:0] rand_op(bit md);
    logic [23:0] r;
    if (md) r = {1'b0, 23'($urandom_range(0, 8380416))};
    else    r = {12'($urandom_range(0, 3328)), 12'($urandom_range(0, 3328))};
    return r;
  endfunction

  task automatic check_out();
    exp_t e;
    if (stage_done === 1'b1) sd_cnt++;
    if (out_valid === 1'b1) begin
      if (exp_q.size() == 0 || exp_q[0].due != cyc) begin
        cmp("unexpected_out_valid", 32'(out_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        cmp("x", 32'(x), 32'(e.x));
        cmp("y", 32'(y), 32'(e.y));
        cmp("out_idx", 32'(out_idx), 32'(idx_m));
        cmp("stage_done", 32'(stage_done), 32'(idx_m == BF - 1));
      end
      idx_m = (idx_m + 1) % BF;
    end else begin
      if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
        cmp("missing_out_valid", 32'(out_valid), 32'd1);
        void'(exp_q.pop_front());
      end
      cmp("stage_done_idle", 32'(stage_done), 32'd0);
    end
  endtask

  task automatic step(bit iv, bit md, bit he, logic [23:0] uu, logic [23:0] tt,
                      logic [23:0] ex, logic [23:0] ey, bit track);
    tdrv_t d;
    @(negedge clk);
    cyc++;
    check_out();
    in_valid = iv;
    mode     = iv ? md : 1'($urandom);
    half_en  = iv ? he : 1'($urandom);
    u        = iv ? uu : 24'($urandom);
    if (t_q.size() != 0 && t_q[0].tcyc == cyc) begin
      d = t_q.pop_front();
      t = d.t;
    end else begin
      t = 24'($urandom) | 24'd1;
    end
    if (iv && track) begin
      t_q.push_back('{cyc + MUL_LAT, tt});
      exp_q.push_back('{cyc + MUL_LAT + 2, ex, ey});
    end
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 24'd0, 24'd0, 24'd0, 24'd0, 1'b0);
  endtask

  task automatic drain();
    repeat (MUL_LAT + 4) idle();
  endtask

  task automatic check_zero(string tag);
    cmp({tag, "_out_valid"},  32'(out_valid), 32'd0);
    cmp({tag, "_x"},          32'(x), 32'd0);
    cmp({tag, "_y"},          32'(y), 32'd0);
    cmp({tag, "_out_idx"},    32'(out_idx), 32'd0);
    cmp({tag, "_stage_done"}, 32'(stage_done), 32'd0);
  endtask

  task automatic reset_and_check(int low_cycles, int after_cycles);
    rst = 1'b0;
    exp_q.delete();
    t_q.delete();
    idx_m = 0;
    repeat (low_cycles) begin idle(); check_zero("rst_low"); end
    rst = 1'b1;
    repeat (after_cycles) begin idle(); check_zero("rst_after"); end
  endtask

  task automatic issue_rand(bit md, bit he);
    logic [23:0] a, b;
    a = rand_op(md);
    b = rand_op(md);
    step(1'b1, md, he, a, b, ref_bf(md, he, a, b, 1'b0), ref_bf(md, he, a, b, 1'b1), 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{1'b0, 1'b0, {12'd100, 12'd3000}, {12'd3300, 12'd500}, {12'd71, 12'd171}, {12'd129, 12'd2500}};
    vt[1] = '{1'b1, 1'b1, 24'd8380000, 24'd1000, 24'd4190500, 24'd4189500};
    vt[2] = '{1'b1, 1'b0, 24'd8380000, 24'd1000, 24'd583, 24'd8379000};
    vt[3] = '{1'b0, 1'b1, {12'd1, 12'd0}, 24'd0, {12'd1665, 12'd0}, {12'd1665, 12'd0}};
    vt[4] = '{1'b0, 1'b0, {12'd3328, 12'd0}, {12'd1, 12'd0}, 24'd0, {12'd3327, 12'd0}};
    vt[5] = '{1'b1, 1'b0, 24'd0, 24'd1, 24'd1, 24'd8380416};
    vt[6] = '{1'b1, 1'b1, 24'd8380416, 24'd8380416, 24'd8380416, 24'd0};
    vt[7] = '{1'b0, 1'b1, {12'd3328, 12'd3328}, {12'd3328, 12'd0}, {12'd3328, 12'd1664}, {12'd0, 12'd1664}};

    rst = 1'b1;
    #1 rst = 1'b0;
    repeat (3) begin idle(); check_zero("reset"); end

    // Fixed vectors; the first issue lands in the first cycle after reset release.
    for (int i = 0; i < 8; i++) begin
      step(1'b1, vt[i].md, vt[i].he, vt[i].u, vt[i].t, vt[i].ex, vt[i].ey, 1'b1);
      if (i == 0) rst = 1'b1;
      idle();
      idle();
    end
    drain();

    // Reset while three butterflies are in flight.
    repeat (3) step(1'b1, 1'b0, 1'b0, rand_op(1'b0), 24'd0, 24'd0, 24'd0, 1'b0);
    idle();
    idle();
    reset_and_check(2, 10);
    step(1'b1, vt[0].md, vt[0].he, vt[0].u, vt[0].t, vt[0].ex, vt[0].ey, 1'b1);
    drain();

    // Full stage back-to-back, then one more to see the index wrap.
    reset_and_check(2, 2);
    sd_cnt = 0;
    for (int i = 0; i < BF; i++) issue_rand(1'(i % 2), 1'($urandom));
    issue_rand(1'b0, 1'b0);
    drain();
    cmp("stage_done_count", 32'(sd_cnt), 32'd1);

    // Sparse random traffic in both modes.
    for (int k = 0; k < 10000; k++) begin
      issue_rand(1'($urandom), 1'($urandom));
      repeat ($urandom_range(0, 2)) idle();
    end
    drain();
    cmp("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
